// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing a single uart_tx among N_REQ byte requesters.
// Issues one write strobe per grant, then follows tx_busy to report completion.
//
// state        | meaning
// S_IDLE       | searching req_valid from rr_ptr; latch winner byte
// S_ISSUE      | one-cycle strobe to transmitter, req_ready to owner
// S_WAIT_BUSY  | waiting for tx_busy to rise, bounded by START_TIMEOUT
// S_WAIT_DONE  | byte shifting out; tx_busy falling ends the transfer
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     done,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    output logic                 tx_cs_n,
    input  logic                 tx_busy,
    output logic [2:0]           grant_id,
    output logic                 active,
    output logic                 err_timeout
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(START_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] rr_ptr, rr_ptr_nxt;
    logic [PW-1:0] grant_q, grant_nxt;
    logic [PW-1:0] pick_idx;
    logic          pick_found;
    logic [7:0]    pick_byte;
    logic [7:0]    tx_data_q, tx_data_nxt;
    logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
    logic          err_q, err_nxt;

    // Increment modulo N_REQ; explicit compare keeps non-power-of-two sizes correct.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        if (v == PW'(N_REQ - 1)) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    always_comb begin
        int            cand;
        logic [PW-1:0] cidx;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cidx = PW'(cand);
            if (!pick_found && req_valid[cidx]) begin
                pick_found = 1'b1;
                pick_idx   = cidx;
            end
        end
    end

    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == PW'(i)) begin
                pick_byte = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        grant_nxt     = grant_q;
        tx_data_nxt   = tx_data_q;
        tmo_cnt_nxt   = tmo_cnt;
        err_nxt       = err_q;
        req_ready     = '0;
        done          = '0;
        tx_data_valid = 1'b0;
        tx_cs_n       = 1'b1;
        active        = 1'b0;

        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    grant_nxt   = pick_idx;
                    tx_data_nxt = pick_byte;
                    state_nxt   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                active             = 1'b1;
                tx_data_valid      = 1'b1;
                tx_cs_n            = 1'b0;
                req_ready[grant_q] = 1'b1;
                tmo_cnt_nxt        = '0;
                state_nxt          = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                active = 1'b1;
                if (tx_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (tmo_cnt == CW'(START_TIMEOUT - 1)) begin
                    err_nxt    = 1'b1;
                    rr_ptr_nxt = wrap_inc(grant_q);
                    state_nxt  = S_IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                active = 1'b1;
                if (!tx_busy) begin
                    done[grant_q] = 1'b1;
                    rr_ptr_nxt    = wrap_inc(grant_q);
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Reset wins even over a tx_busy fall seen in the same cycle.
        if (reset) begin
            req_ready     = '0;
            done          = '0;
            tx_data_valid = 1'b0;
            tx_cs_n       = 1'b1;
            active        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant_q   <= '0;
            tx_data_q <= '0;
            tmo_cnt   <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant_q   <= grant_nxt;
            tx_data_q <= tx_data_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            err_q     <= err_nxt;
        end
    end

    always_comb begin
        grant_id           = '0;
        grant_id[PW-1:0]   = grant_q;
    end

    assign tx_data     = tx_data_q;
    assign err_timeout = err_q;

endmodule
